// File: rtl/bp_update_scheduler_pkg.sv
// bp_update_scheduler_pkg: queue entry layout and helpers for the branch-update scheduler
package bp_update_scheduler_pkg;
  localparam int PC_W = 32;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            br;
  } bp_entry_t;
  function automatic logic [1:0] enq_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/bp_update_fifo.sv
// bp_update_fifo: 2-write/1-read circular buffer of branch outcomes with occupancy count
module bp_update_fifo
  import bp_update_scheduler_pkg::*;
#(
  parameter int QW = 3
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         wr0_en,
  input  bp_entry_t    wr0_data,
  input  logic         wr1_en,
  input  bp_entry_t    wr1_data,
  input  logic         rd_en,
  output bp_entry_t    rd_data,
  output logic [QW:0]  count
);
  localparam int DEPTH = 2 ** QW;
  bp_entry_t       mem [DEPTH];
  logic [QW-1:0]   head, tail, tail_p1;
  logic [1:0]      enq;
  assign enq     = enq_count(wr0_en, wr1_en);
  assign tail_p1 = tail + QW'(1);
  assign rd_data = mem[head];
  // storage writes: slot 1 is only used together with slot 0, so it always lands at tail+1
  always_ff @(posedge clk_in) begin
    if (wr0_en) mem[tail] <= wr0_data;
    if (wr1_en) mem[tail_p1] <= wr1_data;
  end
  // pointers wrap naturally at DEPTH; count tracks simultaneous push/pop
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + QW'(rd_en);
      tail  <= tail + QW'(enq);
      count <= count + (QW + 1)'(enq) - (QW + 1)'(rd_en);
    end
  end
endmodule

// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: serialises dual-port ROB branch commits into a single predictor update port
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int QUEUE_WIDTH = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   rob_to_bus_valid0,
  input  logic [31:0]            rob_to_bus_pc0,
  input  logic                   rob_to_bus_br0,
  input  logic                   rob_to_bus_valid1,
  input  logic [31:0]            rob_to_bus_pc1,
  input  logic                   rob_to_bus_br1,
  output logic                   bus_to_rob_ready,
  output logic                   bus_to_bp_ready,
  output logic [31:0]            bus_to_bp_pc,
  output logic                   bus_to_bp_actual_br,
  output logic [QUEUE_WIDTH:0]   bus_count
);
  localparam int DEPTH = 2 ** QUEUE_WIDTH;
  localparam logic [QUEUE_WIDTH:0] READY_MAX = (QUEUE_WIDTH + 1)'(DEPTH - 2);
  logic      acc, deq;
  bp_entry_t e0, e1, head_entry;
  assign bus_to_rob_ready = bus_count <= READY_MAX;
  assign acc = rdy_in & bus_to_rob_ready;
  assign deq = rdy_in & (bus_count != '0);
  assign e0  = rob_to_bus_valid0 ? {rob_to_bus_pc0, rob_to_bus_br0} : {rob_to_bus_pc1, rob_to_bus_br1};
  assign e1  = {rob_to_bus_pc1, rob_to_bus_br1};
  bp_update_fifo #(.QW(QUEUE_WIDTH)) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .wr0_en   (acc & (rob_to_bus_valid0 | rob_to_bus_valid1)),
    .wr0_data (e0),
    .wr1_en   (acc & rob_to_bus_valid0 & rob_to_bus_valid1),
    .wr1_data (e1),
    .rd_en    (deq),
    .rd_data  (head_entry),
    .count    (bus_count)
  );
  // output register: one update per ready cycle, pc/br hold when nothing issues
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus_to_bp_ready     <= 1'b0;
      bus_to_bp_pc        <= '0;
      bus_to_bp_actual_br <= 1'b0;
    end else if (rdy_in) begin
      bus_to_bp_ready <= deq;
      if (deq) begin
        bus_to_bp_pc        <= head_entry.pc;
        bus_to_bp_actual_br <= head_entry.br;
      end
    end
  end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb_bp_update_scheduler: table-driven and directed checks of the branch-update scheduler
module tb_bp_update_scheduler;
  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b0;
  logic        v0 = 1'b0, br0 = 1'b0, v1 = 1'b0, br1 = 1'b0;
  logic [31:0] pc0 = '0, pc1 = '0;
  logic        bus_to_rob_ready, bus_to_bp_ready, bus_to_bp_actual_br;
  logic [31:0] bus_to_bp_pc;
  logic [3:0]  bus_count;
  int          vec_n = 0, miss_n = 0;
  logic [32:0] sb [$];

  typedef struct {
    logic a0; logic [31:0] p0; logic b0;
    logic a1; logic [31:0] p1; logic b1;
    logic e_rdy; logic [31:0] e_pc; logic e_br; logic [3:0] e_cnt; logic e_rob;
  } vec_t;
  vec_t tbl [11];

  bp_update_scheduler #(.QUEUE_WIDTH(3)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .rob_to_bus_valid0   (v0),
    .rob_to_bus_pc0      (pc0),
    .rob_to_bus_br0      (br0),
    .rob_to_bus_valid1   (v1),
    .rob_to_bus_pc1      (pc1),
    .rob_to_bus_br1      (br1),
    .bus_to_rob_ready    (bus_to_rob_ready),
    .bus_to_bp_ready     (bus_to_bp_ready),
    .bus_to_bp_pc        (bus_to_bp_pc),
    .bus_to_bp_actual_br (bus_to_bp_actual_br),
    .bus_count           (bus_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic a0, input logic [31:0] p0, input logic b0,
                      input logic a1, input logic [31:0] p1, input logic b1, input logic r);
    logic acc;
    @(negedge clk_in);
    v0 = a0; pc0 = p0; br0 = b0; v1 = a1; pc1 = p1; br1 = b1; rdy_in = r;
    acc = r & bus_to_rob_ready;
    @(posedge clk_in);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    if (acc) begin
      if (a0) sb.push_back({p0, b0});
      if (a1) sb.push_back({p1, b1});
    end
    if (r && bus_to_bp_ready) begin
      if (sb.size() == 0) check("issue_unexpected", 64'(bus_to_bp_ready), 64'd0);
      else check("issue_order", 64'({bus_to_bp_pc, bus_to_bp_actual_br}), 64'(sb.pop_front()));
    end
    check("occupancy", 64'(bus_count), 64'(sb.size()));
    check("rob_ready", 64'(bus_to_rob_ready), 64'(sb.size() <= 6));
  endtask

  task automatic idle(input logic r);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, r);
  endtask

  initial begin
    logic saw_full;
    int   k;
    tbl[0]  = '{0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h0,    0, 4'd0, 1};
    tbl[1]  = '{1, 32'h1000, 1, 0, 32'h0,    0, 0, 32'h0,    0, 4'd1, 1};
    tbl[2]  = '{0, 32'h0,    0, 0, 32'h0,    0, 1, 32'h1000, 1, 4'd0, 1};
    tbl[3]  = '{0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h1000, 1, 4'd0, 1};
    tbl[4]  = '{1, 32'h2000, 0, 1, 32'h2004, 1, 0, 32'h1000, 1, 4'd2, 1};
    tbl[5]  = '{0, 32'h0,    0, 0, 32'h0,    0, 1, 32'h2000, 0, 4'd1, 1};
    tbl[6]  = '{0, 32'h0,    0, 0, 32'h0,    0, 1, 32'h2004, 1, 4'd0, 1};
    tbl[7]  = '{0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h2004, 1, 4'd0, 1};
    tbl[8]  = '{0, 32'h0,    0, 1, 32'h3000, 0, 0, 32'h2004, 1, 4'd1, 1};
    tbl[9]  = '{0, 32'h0,    0, 0, 32'h0,    0, 1, 32'h3000, 0, 4'd0, 1};
    tbl[10] = '{0, 32'h0,    0, 0, 32'h0,    0, 0, 32'h3000, 0, 4'd0, 1};
    #12;
    check("reset_state", 64'({bus_to_bp_ready, bus_to_bp_pc, bus_to_bp_actual_br, bus_count, bus_to_rob_ready}),
          64'({1'b0, 32'h0, 1'b0, 4'd0, 1'b1}));
    rst_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      check("idle", 64'({bus_to_bp_ready, bus_count, bus_to_rob_ready}), 64'({1'b0, 4'd0, 1'b1}));
    end
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].a0, tbl[i].p0, tbl[i].b0, tbl[i].a1, tbl[i].p1, tbl[i].b1, 1'b1);
      check($sformatf("vec%0d", i),
            64'({bus_to_bp_ready, bus_to_bp_pc, bus_to_bp_actual_br, bus_count, bus_to_rob_ready}),
            64'({tbl[i].e_rdy, tbl[i].e_pc, tbl[i].e_br, tbl[i].e_cnt, tbl[i].e_rob}));
    end
    saw_full = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      logic was;
      was = bus_to_rob_ready;
      step(1'b1, 32'h4000 + 32'(k * 8), k[0], 1'b1, 32'h4004 + 32'(k * 8), ~k[0], 1'b1);
      if (!bus_to_rob_ready && bus_count == 4'd7) saw_full = 1'b1;
      if (was) k++;
    end
    check("fill_all_accepted", 64'(k), 64'd8);
    check("fill_backpressure", 64'(saw_full), 64'd1);
    for (int c = 0; c < 20; c++) idle(1'b1);
    check("fill_drained", 64'({bus_count, bus_to_bp_ready}), 64'({4'd0, 1'b0}));
    check("fill_model_empty", 64'(sb.size()), 64'd0);
    step(1'b1, 32'h6000, 1'b1, 1'b1, 32'h6004, 1'b0, 1'b1);
    step(1'b1, 32'h6008, 1'b1, 1'b1, 32'h600c, 1'b1, 1'b1);
    check("stall_setup", 64'({bus_to_bp_ready, bus_to_bp_pc, bus_count}), 64'({1'b1, 32'h6000, 4'd3}));
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check("stall_frozen", 64'({bus_to_bp_ready, bus_to_bp_pc, bus_to_bp_actual_br, bus_count}),
            64'({1'b1, 32'h6000, 1'b1, 4'd3}));
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("stall_resume", 64'(bus_to_bp_ready), 64'd1);
    end
    idle(1'b1);
    check("stall_done", 64'({bus_to_bp_ready, bus_count}), 64'({1'b0, 4'd0}));
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h7000 + 32'(i * 8), 1'b1, 1'b1, 32'h7004 + 32'(i * 8), 1'b0, 1'b1);
    check("burst_count", 64'(bus_count), 64'd5);
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("async_reset", 64'({bus_to_bp_ready, bus_to_bp_pc, bus_count, bus_to_rob_ready}),
          64'({1'b0, 32'h0, 4'd0, 1'b1}));
    sb.delete();
    #1 rst_in = 1'b0;
    step(1'b1, 32'h8000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check("post_reset_queued", 64'({bus_to_bp_ready, bus_count}), 64'({1'b0, 4'd1}));
    idle(1'b1);
    check("post_reset_issue", 64'({bus_to_bp_ready, bus_to_bp_pc, bus_to_bp_actual_br}),
          64'({1'b1, 32'h8000, 1'b1}));
    idle(1'b1);
    check("post_reset_idle", 64'(bus_to_bp_ready), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end
endmodule
